// File: rtl/pe_tile_loader_if.sv
// ---------------------------------------------------------------------------
// pe_tile_loader_if
//   Bundles the tile loader's request/response and controller-facing signals.
//
//   start / w_base / d_base        : tile run request and the two tile base
//                                    word addresses
//   rd_en / rd_addr                : buffer read request and its address
//   rd_valid / rd_data             : in-order buffer read response
//   weights_out / datas_out        : unpacked signed weight and data tiles,
//                                    row-major (index r*ARRAY_SIZE+c)
//   load_en / compute              : controller weight-load strobe and compute
//                                    enable
//   busy / done / proto_err        : status outputs
//
//   Modport slave is the loader's view; modport master is the view of the
//   block driving requests and serving the buffer.
// ---------------------------------------------------------------------------
interface pe_tile_loader_if #(
    parameter int ARRAY_SIZE         = 8,
    parameter int COMPUTE_DATA_WIDTH = 4,
    parameter int BUFFER_WORD_SIZE   = 16,
    parameter int ADDR_WIDTH         = 10
);
    localparam int N_ELEM = ARRAY_SIZE * ARRAY_SIZE;

    logic                                 start;
    logic        [ADDR_WIDTH-1:0]         w_base;
    logic        [ADDR_WIDTH-1:0]         d_base;
    logic                                 rd_en;
    logic        [ADDR_WIDTH-1:0]         rd_addr;
    logic                                 rd_valid;
    logic        [BUFFER_WORD_SIZE-1:0]   rd_data;
    logic signed [COMPUTE_DATA_WIDTH-1:0] weights_out [N_ELEM];
    logic signed [COMPUTE_DATA_WIDTH-1:0] datas_out   [N_ELEM];
    logic                                 load_en;
    logic                                 compute;
    logic                                 busy;
    logic                                 done;
    logic                                 proto_err;

    modport slave (
        input  start, w_base, d_base, rd_valid, rd_data,
        output rd_en, rd_addr, weights_out, datas_out,
               load_en, compute, busy, done, proto_err
    );

    modport master (
        output start, w_base, d_base, rd_valid, rd_data,
        input  rd_en, rd_addr, weights_out, datas_out,
               load_en, compute, busy, done, proto_err
    );
endinterface

// File: rtl/pe_tile_loader.sv
// ---------------------------------------------------------------------------
// pe_tile_loader
//   Upstream feeder for the PE array controller. A start pulse accepted in
//   IDLE fetches one weight tile, then one data tile, from the on-chip buffer
//   as packed words, unpacks each word into NUM_COMPUTE_LANES signed elements
//   (lane 0 in the LSBs), strobes load_en for one cycle, then holds compute
//   for COMPUTE_CYCLES cycles and pulses done.
//
//   Ports:
//     i_clk    : clock
//     i_rst_n  : asynchronous active-low reset
//     if_bus   : pe_tile_loader_if.slave (request, buffer read port,
//                unpacked tiles, controller strobes, status)
// ---------------------------------------------------------------------------
module pe_tile_loader #(
    parameter int ARRAY_SIZE         = 8,
    parameter int COMPUTE_DATA_WIDTH = 4,
    parameter int BUFFER_WORD_SIZE   = 16,
    parameter int NUM_COMPUTE_LANES  = BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH,
    parameter int ADDR_WIDTH         = 10,
    parameter int WORDS_PER_TILE     = ARRAY_SIZE * ARRAY_SIZE / NUM_COMPUTE_LANES,
    parameter int COMPUTE_CYCLES     = 3 * ARRAY_SIZE
) (
    input logic              i_clk,
    input logic              i_rst_n,
    pe_tile_loader_if.slave  if_bus
);

    localparam int N_ELEM = ARRAY_SIZE * ARRAY_SIZE;
    localparam int CDW    = COMPUTE_DATA_WIDTH;
    localparam int LANES  = NUM_COMPUTE_LANES;
    localparam int IDXW   = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNTW   = $clog2(WORDS_PER_TILE + 1);
    localparam int CCW    = $clog2(COMPUTE_CYCLES + 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    generate
        if (LANES * CDW != BUFFER_WORD_SIZE) begin : g_err_lanes
            $error("pe_tile_loader: BUFFER_WORD_SIZE must be NUM_COMPUTE_LANES*COMPUTE_DATA_WIDTH");
        end
        if (WORDS_PER_TILE * LANES != N_ELEM) begin : g_err_tile
            $error("pe_tile_loader: tile size must divide evenly by NUM_COMPUTE_LANES");
        end
        if (COMPUTE_CYCLES < 1) begin : g_err_cc
            $error("pe_tile_loader: COMPUTE_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        FETCH_W,
        FETCH_D,
        LOAD,
        COMPUTE,
        DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [ADDR_WIDTH-1:0]   r_w_base;
    logic [ADDR_WIDTH-1:0]   r_d_base;
    logic [CNTW-1:0]         r_issue;
    logic [CNTW-1:0]         r_resp;
    logic [CCW-1:0]          r_ccnt;
    logic                    r_perr;

    logic signed [CDW-1:0]   r_weights [N_ELEM];
    logic signed [CDW-1:0]   r_datas   [N_ELEM];

    logic                    w_fetch;
    logic                    w_issue;
    logic                    w_accept;
    logic                    w_spur;
    logic                    w_last_resp;
    logic [IDXW-1:0]         w_elem_base;
    logic signed [CDW-1:0]   w_lane [LANES];

    logic                    w_rd_en;
    logic [ADDR_WIDTH-1:0]   w_rd_addr;
    logic                    w_load_en;
    logic                    w_compute;
    logic                    w_busy;
    logic                    w_done;

    // ------------------------------------------------------------------
    // Read bookkeeping shared by both fetch phases
    // ------------------------------------------------------------------
    assign w_fetch     = (r_state == FETCH_W) || (r_state == FETCH_D);
    assign w_issue     = w_fetch && (r_issue < CNTW'(WORDS_PER_TILE));
    // Responses never outnumber issues, so "outstanding" is issue != resp.
    assign w_accept    = if_bus.rd_valid && w_fetch && (r_issue != r_resp);
    assign w_spur      = if_bus.rd_valid && !w_accept;
    assign w_last_resp = w_accept && (r_resp == CNTW'(WORDS_PER_TILE - 1));
    assign w_elem_base = IDXW'(int'(r_resp) * LANES);

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            assign w_lane[g] = if_bus.rd_data[g*CDW +: CDW];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (if_bus.start) w_next = FETCH_W;
            FETCH_W: if (w_last_resp)  w_next = FETCH_D;
            FETCH_D: if (w_last_resp)  w_next = LOAD;
            LOAD:    w_next = COMPUTE;
            COMPUTE: if (r_ccnt == CCW'(COMPUTE_CYCLES - 1)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_en   = w_issue;
        w_rd_addr = ((r_state == FETCH_D) ? r_d_base : r_w_base) + ADDR_WIDTH'(r_issue);
        w_load_en = (r_state == LOAD);
        w_compute = (r_state == COMPUTE);
        w_busy    = (r_state != IDLE);
        w_done    = (r_state == DONE);
    end

    // ------------------------------------------------------------------
    // Base addresses, captured only on an accepted start
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_w_base <= '0;
            r_d_base <= '0;
        end else if (r_state == IDLE && if_bus.start) begin
            r_w_base <= if_bus.w_base;
            r_d_base <= if_bus.d_base;
        end
    end

    // ------------------------------------------------------------------
    // Issue/response counters; both restart at each phase boundary so the
    // data phase never overlaps the weight phase.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_issue <= '0;
            r_resp  <= '0;
        end else if (!w_fetch || w_last_resp) begin
            r_issue <= '0;
            r_resp  <= '0;
        end else begin
            if (w_issue)  r_issue <= r_issue + 1'b1;
            if (w_accept) r_resp  <= r_resp + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Compute hold counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ccnt <= '0;
        end else if (r_state == COMPUTE) begin
            r_ccnt <= r_ccnt + 1'b1;
        end else begin
            r_ccnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Sticky protocol error: response with nothing outstanding
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perr <= 1'b0;
        end else if (w_spur) begin
            r_perr <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Element arrays: written only by accepted fetch responses
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_weights <= '{default: '0};
            r_datas   <= '{default: '0};
        end else if (w_accept) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (r_state == FETCH_W) begin
                    r_weights[w_elem_base + IDXW'(l)] <= w_lane[LW'(l)];
                end else begin
                    r_datas[w_elem_base + IDXW'(l)] <= w_lane[LW'(l)];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Interface outputs
    // ------------------------------------------------------------------
    assign if_bus.rd_en       = w_rd_en;
    assign if_bus.rd_addr     = w_rd_addr;
    assign if_bus.load_en     = w_load_en;
    assign if_bus.compute     = w_compute;
    assign if_bus.busy        = w_busy;
    assign if_bus.done        = w_done;
    assign if_bus.proto_err   = r_perr;
    assign if_bus.weights_out = r_weights;
    assign if_bus.datas_out   = r_datas;

endmodule

// File: tb/tb_pe_tile_loader.sv
// ---------------------------------------------------------------------------
// tb_pe_tile_loader
//   Directed bench for pe_tile_loader. A buffer model answers reads after a
//   configurable latency; a timeline model derived from the start cycle and
//   latency predicts every strobe, read address and the unpacked tiles.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pe_tile_loader;

    localparam int AS    = 8;
    localparam int CDW   = 4;
    localparam int BWS   = 16;
    localparam int AW    = 10;
    localparam int NE    = AS * AS;
    localparam int LANES = BWS / CDW;
    localparam int WPT   = NE / LANES;
    localparam int CC    = 3 * AS;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pe_tile_loader_if #(
        .ARRAY_SIZE(AS), .COMPUTE_DATA_WIDTH(CDW),
        .BUFFER_WORD_SIZE(BWS), .ADDR_WIDTH(AW)
    ) bus ();

    pe_tile_loader #(
        .ARRAY_SIZE(AS), .COMPUTE_DATA_WIDTH(CDW),
        .BUFFER_WORD_SIZE(BWS), .ADDR_WIDTH(AW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .if_bus  (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] mem [1024];
    int          lat      = 1;
    bit          spur_req = 1'b0;

    // Model state
    bit          m_active   = 1'b0;
    bit          m_arr_zero = 1'b1;
    bit          m_perr     = 1'b0;
    int          m_start    = 0;
    int          m_L        = 1;
    logic [9:0]  m_wb       = '0;
    logic [9:0]  m_db       = '0;

    int n_checks = 0;
    int n_err    = 0;
    int n_done   = 0;
    int done_cyc = 0;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Element e of a tile based at word address base
    function automatic int exp_elem(input logic [9:0] base, input int e);
        logic [9:0]        a;
        logic [15:0]       w;
        logic signed [3:0] v;
        a = base + 10'(e / LANES);
        w = mem[a];
        v = w[(e % LANES) * CDW +: CDW];
        return int'(v);
    endfunction

    // ------------------------------------------------------------------
    // Buffer responder: in-order, fixed latency lat
    // ------------------------------------------------------------------
    typedef struct {
        int         due;
        logic [9:0] a;
    } req_t;
    req_t q[$];
    bit   spur_last = 1'b0;

    initial begin
        req_t r;
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) q.delete();
            else if (bus.rd_en === 1'b1) begin
                r.due = cyc + lat;
                r.a   = bus.rd_addr;
                q.push_back(r);
            end
            @(posedge clk);
            #1;
            if (spur_last) begin
                m_perr    = 1'b1;
                spur_last = 1'b0;
            end
            bus.rd_valid = 1'b0;
            if (spur_req) begin
                bus.rd_valid = 1'b1;
                bus.rd_data  = 16'h5A5A;
                spur_req     = 1'b0;
                spur_last    = 1'b1;
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                r            = q.pop_front();
                bus.rd_valid = 1'b1;
                bus.rd_data  = mem[r.a];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison against the timeline model
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        int         rel, tl, tt, bad, ev, av;
        bit         e_busy, e_rd, e_load, e_comp, e_done, arr_chk;
        logic [9:0] e_addr;
        e_busy = 0; e_rd = 0; e_load = 0; e_comp = 0; e_done = 0; arr_chk = 0;
        e_addr = '0;
        rel = 0; tl = 0; tt = 0;
        if (rst_n && m_active) begin
            rel    = cyc - m_start;
            tl     = 2 * (WPT + m_L) + 1;
            tt     = tl + CC + 1;
            e_busy = (rel >= 1) && (rel <= tt);
            if (rel >= 1 && rel <= WPT) begin
                e_rd   = 1;
                e_addr = m_wb + 10'(rel - 1);
            end
            if (rel >= WPT + m_L + 1 && rel <= 2 * WPT + m_L) begin
                e_rd   = 1;
                e_addr = m_db + 10'(rel - WPT - m_L - 1);
            end
            e_load  = (rel == tl);
            e_comp  = (rel >= tl + 1) && (rel <= tl + CC);
            e_done  = (rel == tt);
            arr_chk = (rel >= tl);
        end
        if (bus.done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        chk("busy",      bus.busy,      e_busy);
        chk("rd_en",     bus.rd_en,     e_rd);
        chk("load_en",   bus.load_en,   e_load);
        chk("compute",   bus.compute,   e_comp);
        chk("done",      bus.done,      e_done);
        chk("proto_err", bus.proto_err, m_perr);
        if (e_rd) chk("rd_addr", bus.rd_addr, e_addr);
        if (m_arr_zero || arr_chk) begin
            bad = -1;
            for (int i = 0; i < NE; i++) begin
                ev = m_arr_zero ? 0 : exp_elem(m_wb, i);
                if (bad < 0 && bus.weights_out[i] !== 4'(ev)) bad = i;
            end
            if (bad < 0) bad = 0;
            ev = m_arr_zero ? 0 : exp_elem(m_wb, bad);
            av = bus.weights_out[bad];
            chk($sformatf("weights_out[%0d]", bad), av, ev);
            bad = -1;
            for (int i = 0; i < NE; i++) begin
                ev = m_arr_zero ? 0 : exp_elem(m_db, i);
                if (bad < 0 && bus.datas_out[i] !== 4'(ev)) bad = i;
            end
            if (bad < 0) bad = 0;
            ev = m_arr_zero ? 0 : exp_elem(m_db, bad);
            av = bus.datas_out[bad];
            chk($sformatf("datas_out[%0d]", bad), av, ev);
        end
    end

    // ------------------------------------------------------------------
    // One tile run; optional ignored mid-run start and optional abort
    // ------------------------------------------------------------------
    task automatic run(input logic [9:0] wb, input logic [9:0] db, input int L,
                       input bit mid, input int abort_rel);
        int d0, tt;
        d0  = n_done;
        lat = L;
        tt  = 2 * (WPT + L) + 1 + CC + 1;
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.w_base = wb;
        bus.d_base = db;
        m_wb = wb; m_db = db; m_L = L;
        m_start    = cyc;
        m_active   = 1'b1;
        m_arr_zero = 1'b0;
        for (int i = 1; i <= tt + 4; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (mid && i == 25) begin
                bus.start  = 1'b1;
                bus.w_base = 10'h300;
                bus.d_base = 10'h300;
            end
            if (abort_rel > 0 && i == abort_rel) begin
                rst_n      = 1'b0;
                m_active   = 1'b0;
                m_arr_zero = 1'b1;
                m_perr     = 1'b0;
                #1 chk("abort_compute_low", bus.compute, 0);
            end
            if (abort_rel > 0 && i == abort_rel + 2) rst_n = 1'b1;
        end
        bus.start = 1'b0;
        chk("done_count", n_done - d0, (abort_rel > 0) ? 0 : 1);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.w_base = '0;
        bus.d_base = '0;
        for (int a = 0; a < 1024; a++) mem[a] = 16'(a);

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_w0",   bus.weights_out[0], 0);
        chk("reset_busy", bus.busy, 0);

        // Single tile, L=1
        run(10'h010, 10'h040, 1, 1'b0, 0);
        chk("t1_w0",  bus.weights_out[0], 0);
        chk("t1_w1",  bus.weights_out[1], 1);
        chk("t1_w2",  bus.weights_out[2], 0);
        chk("t1_w4",  bus.weights_out[4], 1);
        chk("t1_d1",  bus.datas_out[1],   4);
        chk("t1_lat", done_cyc - m_start, 60);

        // Sign / lane order
        mem[10'h100] = 16'h8F70;
        run(10'h100, 10'h200, 1, 1'b0, 0);
        chk("sign_w0", bus.weights_out[0], 0);
        chk("sign_w1", bus.weights_out[1], 7);
        chk("sign_w2", bus.weights_out[2], -1);
        chk("sign_w3", bus.weights_out[3], -8);

        // Address wrap
        run(10'h3FA, 10'h080, 2, 1'b0, 0);
        chk("wrap_w20", bus.weights_out[20], -1);
        chk("wrap_w21", bus.weights_out[21], -1);
        chk("wrap_w22", bus.weights_out[22], 3);
        chk("wrap_w25", bus.weights_out[25], 0);

        // L=5 with an ignored start during the data fetch
        run(10'h020, 10'h060, 5, 1'b1, 0);
        chk("l5_lat", done_cyc - m_start, 68);
        chk("l5_w1",  bus.weights_out[1], 2);
        chk("l5_d1",  bus.datas_out[1],   6);

        // Spurious response while idle
        spur_req = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("perr_set", bus.proto_err, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("perr_sticky", bus.proto_err, 1);

        // Reset in the middle of COMPUTE (load_en at rel 35)
        run(10'h010, 10'h040, 1, 1'b0, 41);
        chk("abort_perr", bus.proto_err, 0);
        chk("abort_w1",   bus.weights_out[1], 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
